// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the HPS input PIO: register map, edge encodings, bus width.
package soc_system_pio_pkg;

    localparam int AVALON_DW = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

endpackage

// File: rtl/soc_system_pio_sync_debounce.sv
// One input bit: synchroniser chain followed by an optional consecutive-clock debouncer.
module soc_system_pio_sync_debounce
    import soc_system_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_raw,
    output logic o_stable
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_raw = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No debounce: the stable copy is just one register stage behind the synchroniser.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stable <= 1'b0;
                end else begin
                    r_stable <= o_raw;
                end
            end
        end else begin : g_debounce
            localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

            logic [CW-1:0] r_cnt;

            // Accept a new level only after it has differed from stable for N consecutive clocks.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (o_raw == r_stable) begin
                    r_cnt    <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_stable <= o_raw;
                    r_cnt    <= '0;
                end else begin
                    r_cnt    <= r_cnt + CNT_ONE;
                end
            end
        end
    endgenerate

    assign o_stable = r_stable;

endmodule

// File: rtl/soc_system_pio_in_edge_irq.sv
// Avalon-MM input PIO with synchronisation, debounce, W1C edge capture and a masked level IRQ.
module soc_system_pio_in_edge_irq
    import soc_system_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    SYNC_STAGES     = 2,
    parameter int                    DEBOUNCE_CYCLES = 0,
    parameter int                    EDGE_TYPE       = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_MASK      = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] w_raw;
    logic [DATA_WIDTH-1:0] w_stable;
    logic [DATA_WIDTH-1:0] r_stable_d;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_edge;
    logic                  r_irq;
    logic [31:0]           r_readdata;

    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rise;
    logic [DATA_WIDTH-1:0] w_fall;
    logic [DATA_WIDTH-1:0] w_edge_hit;
    logic [DATA_WIDTH-1:0] w_edge_clr;
    logic [DATA_WIDTH-1:0] w_edge_next;
    logic [31:0]           w_rd_mux;
    logic                  w_unused_wdata;

    genvar k;
    generate
        for (k = 0; k < DATA_WIDTH; k++) begin : g_bit
            soc_system_pio_sync_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_sync_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_async  (in_port[k]),
                .o_raw    (w_raw[k]),
                .o_stable (w_stable[k])
            );
        end
    endgenerate

    assign w_wr_en        = chipselect & ~write_n;
    assign w_rise         = w_stable & ~r_stable_d;
    assign w_fall         = ~w_stable & r_stable_d;
    assign w_unused_wdata = ^writedata;

    // Select which transitions of the debounced value count as an edge.
    always_comb begin
        w_edge_hit = '0;
        case (EDGE_TYPE)
            int'(EDGE_RISING):  w_edge_hit = w_rise;
            int'(EDGE_FALLING): w_edge_hit = w_fall;
            default:            w_edge_hit = w_rise | w_fall;
        endcase
    end

    // Next edge-capture value: W1C first, then new edges on top so a coincident set wins.
    always_comb begin
        w_edge_clr = '0;
        if (w_wr_en && (address == ADDR_EDGE)) begin
            w_edge_clr = writedata[DATA_WIDTH-1:0];
        end else begin
            w_edge_clr = '0;
        end
        w_edge_next = (r_edge & ~w_edge_clr) | w_edge_hit;
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux = AVALON_DW'(w_stable);
            ADDR_MASK: w_rd_mux = AVALON_DW'(r_mask);
            ADDR_EDGE: w_rd_mux = AVALON_DW'(r_edge);
            ADDR_RAW:  w_rd_mux = AVALON_DW'(w_raw);
            default:   w_rd_mux = '0;
        endcase
    end

    // Previous-cycle copy of the debounced value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    // IRQ mask register, written by firmware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= RESET_MASK;
        end else if (w_wr_en && (address == ADDR_MASK)) begin
            r_mask <= writedata[DATA_WIDTH-1:0];
        end else begin
            r_mask <= r_mask;
        end
    end

    // Edge capture bits, independent of the mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= '0;
        end else begin
            r_edge <= w_edge_next;
        end
    end

    // Registered level interrupt from masked captured edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge & r_mask);
        end
    end

    // Read data with fixed latency of one clock, updated every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
